// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the general-purpose register file.
package regfile_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int N_DEF     = 8;
  localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/regfile_n_regn.sv
// n-bit loadable register with synchronous clear.
module regn_sc #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [n-1:0] d_i,
  output logic [n-1:0] q_o
);

  logic [n-1:0] q_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/regfile_n.sv
// Register file: one write port, two registered bypassed read ports,
// and a one-word-per-cycle clear sweep.
module regfile_n
  import regfile_pkg::*;
#(
  parameter int n     = N_DEF,
  parameter int depth = DEPTH_DEF,
  parameter int aw    = $clog2(depth)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [aw-1:0] waddr,
  input  logic [n-1:0]  wdata,
  input  logic [aw-1:0] ra0,
  input  logic [aw-1:0] ra1,
  output logic [n-1:0]  rd0,
  output logic [n-1:0]  rd1,
  input  logic          clr,
  output logic          busy,
  output logic          werr
);

  localparam logic [aw:0]   DEPTH_W = (aw+1)'(depth);
  localparam logic [aw-1:0] LAST    = aw'(depth - 1);

  state_e        state_q, state_d;
  logic [aw-1:0] idx_q, idx_d;
  logic [n-1:0]  rd0_q, rd0_d;
  logic [n-1:0]  rd1_q, rd1_d;
  logic          werr_q, werr_d;

  logic [n-1:0]  mem [depth];
  logic          sweep;
  logic          wr_ok;

  assign sweep = (state_q == CLEAR);
  assign wr_ok = !sweep && we &&
                 ({1'b0, waddr} < DEPTH_W);

  for (genvar i = 0; i < depth; i++) begin : g_word
    regn_sc #(.n(n)) u_reg (
      .clk  (clk),
      .rst  (rst),
      .clr_i(sweep && (idx_q == aw'(i))),
      .ld_i (wr_ok && (waddr == aw'(i))),
      .d_i  (wdata),
      .q_o  (mem[i])
    );
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clr) state_d = CLEAR;
      end
      CLEAR: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + aw'(1);
        end
      end
    endcase
  end

  // Sweep zero beats write bypass, which beats the stored word.
  always_comb begin
    rd0_d = '0;
    rd1_d = '0;
    for (int i = 0; i < depth; i++) begin
      if (ra0 == aw'(i)) rd0_d = mem[i];
      if (ra1 == aw'(i)) rd1_d = mem[i];
    end
    if (wr_ok && (waddr == ra0)) rd0_d = wdata;
    if (wr_ok && (waddr == ra1)) rd1_d = wdata;
    if (sweep && (ra0 == idx_q)) rd0_d = '0;
    if (sweep && (ra1 == idx_q)) rd1_d = '0;
  end

  assign werr_d = sweep && we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      werr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      werr_q  <= werr_d;
    end
  end

  assign rd0  = rd0_q;
  assign rd1  = rd1_q;
  assign busy = sweep;
  assign werr = werr_q;

endmodule

// File: tb/tb_regfile_n.sv
// Directed bench for regfile_n: vector table plus sweep/reset sequences.
module tb_regfile_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       we, clr;
  logic [2:0] waddr, ra0, ra1;
  logic [7:0] wdata, rd0, rd1;
  logic       busy, werr;

  logic       we6, clr6;
  logic [2:0] waddr6, ra06, ra16;
  logic [7:0] wdata6, rd06, rd16;
  logic       busy6, werr6;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_n #(.n(8), .depth(8)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr),
    .wdata(wdata), .ra0(ra0), .ra1(ra1), .rd0(rd0),
    .rd1(rd1), .clr(clr), .busy(busy), .werr(werr)
  );

  regfile_n #(.n(8), .depth(6)) dut6 (
    .clk(clk), .rst(rst), .we(we6), .waddr(waddr6),
    .wdata(wdata6), .ra0(ra06), .ra1(ra16), .rd0(rd06),
    .rd1(rd16), .clr(clr6), .busy(busy6), .werr(werr6)
  );

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] r0;
    logic [2:0] r1;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;

  vec_t tv [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic fill();
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h11 * (i + 1)));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    tv[0] = '{1'b1, 3'd3, 8'hE3, 3'd3, 3'd0, 8'hE3, 8'h00};
    tv[1] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd3, 8'hE3, 8'hE3};
    tv[2] = '{1'b1, 3'd5, 8'h5A, 3'd3, 3'd5, 8'hE3, 8'h5A};
    tv[3] = '{1'b0, 3'd0, 8'h00, 3'd5, 3'd0, 8'h5A, 8'h00};
    tv[4] = '{1'b1, 3'd0, 8'h77, 3'd0, 3'd1, 8'h77, 8'h00};
    tv[5] = '{1'b1, 3'd3, 8'h01, 3'd3, 3'd5, 8'h01, 8'h5A};
    tv[6] = '{1'b0, 3'd0, 8'h00, 3'd3, 3'd0, 8'h01, 8'h77};

    rst = 1'b1; we = 0; clr = 0; waddr = 0; wdata = 0;
    ra0 = 0; ra1 = 0;
    we6 = 0; clr6 = 0; waddr6 = 0; wdata6 = 0;
    ra06 = 0; ra16 = 0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_werr", werr, 0);
    chk("rst_rd0", rd0, 0);
    rst = 1'b0;

    for (int a = 0; a < 8; a++) begin
      ra0 = 3'(a); ra1 = 3'(7 - a);
      step();
      chk("init_rd0", rd0, 0);
      chk("init_rd1", rd1, 0);
      chk("init_busy", busy, 0);
    end

    for (int i = 0; i < 7; i++) begin
      we = tv[i].we; waddr = tv[i].wa; wdata = tv[i].wd;
      ra0 = tv[i].r0; ra1 = tv[i].r1;
      step();
      chk($sformatf("vec%0d_rd0", i), rd0, tv[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd1, tv[i].e1);
    end
    we = 1'b0;

    fill();
    ra0 = 3'd2; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("sw_busy_rise", busy, 1);
    chk("sw_rd2_0", rd0, 8'h33);
    cnt = 1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j <= 8) chk($sformatf("sw_rd2_%0d", j), rd0,
                      (j < 3) ? 8'h33 : 8'h00);
      if (busy) cnt++;
      else break;
    end
    chk("sw_len", cnt, 8);
    for (int a = 0; a < 8; a++) begin
      ra0 = 3'(a); ra1 = 3'(a);
      step();
      chk("sw_after_rd0", rd0, 0);
      chk("sw_after_rd1", rd1, 0);
    end

    wr(3'd6, 8'hAB);
    ra0 = 3'd6;
    step();
    chk("pre_w6", rd0, 8'hAB);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ws_busy_rise", busy, 1);
    for (int j = 1; j <= 10; j++) begin
      we = (j == 2); waddr = 3'd6; wdata = 8'hFF;
      clr = (j == 4);
      step();
      chk($sformatf("ws_werr_%0d", j), werr, (j == 2));
      chk($sformatf("ws_busy_%0d", j), busy, (j < 8));
    end
    we = 1'b0; clr = 1'b0;
    ra0 = 3'd6;
    step();
    chk("ws_w6", rd0, 0);

    we = 1'b1; waddr = 3'd0; wdata = 8'h99; clr = 1'b1;
    ra0 = 3'd0;
    step();
    we = 1'b0; clr = 1'b0;
    chk("cw_bypass", rd0, 8'h99);
    chk("cw_busy", busy, 1);
    step();
    chk("cw_zero", rd0, 0);
    for (int j = 0; j < 20; j++) begin
      if (!busy) break;
      step();
    end
    chk("cw_done", busy, 0);
    step();
    chk("cw_w0", rd0, 0);

    fill();
    clr = 1'b1;
    step();
    clr = 1'b0;
    step(); step(); step();
    chk("rm_busy_pre", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_busy", busy, 0);
    chk("rm_werr", werr, 0);
    we = 1'b1; waddr = 3'd7; wdata = 8'h42;
    ra0 = 3'd7; ra1 = 3'd7;
    step();
    we = 1'b0;
    chk("rm_wr_rd0", rd0, 8'h42);
    chk("rm_wr_rd1", rd1, 8'h42);
    step();
    chk("rm_rd7", rd0, 8'h42);
    for (int a = 0; a < 7; a++) begin
      ra0 = 3'(a);
      step();
      chk($sformatf("rm_rd%0d", a), rd0, 0);
    end

    we6 = 1'b1; waddr6 = 3'd7; wdata6 = 8'h99;
    ra06 = 3'd7; ra16 = 3'd5;
    step();
    we6 = 1'b0;
    chk("oor_rd7", rd06, 0);
    chk("oor_rd5", rd16, 0);
    chk("oor_werr", werr6, 0);
    we6 = 1'b1; waddr6 = 3'd6; wdata6 = 8'h77;
    ra06 = 3'd6;
    step();
    we6 = 1'b0;
    chk("oor_werr2", werr6, 0);
    chk("oor_rd6", rd06, 0);
    we6 = 1'b1; waddr6 = 3'd5; wdata6 = 8'h21;
    ra06 = 3'd7;
    step();
    we6 = 1'b0;
    chk("oor_ok5", rd16, 8'h21);
    chk("oor_rd7b", rd06, 0);
    step();
    chk("oor_hold5", rd16, 8'h21);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_n.md
# regfile_n

Parametrised register file: `depth` words of `n` bits each, built from loadable registers with synchronous clear. It has one write port, two registered read ports with write-through bypass, and a multi-cycle clear-sweep engine. It sits between the datapath and the control unit as the general-purpose register store in place of discrete loadable registers.

## Interface
Parameters:
- `n`, default 8: word width in bits, ≥1.
- `depth`, default 8: number of words, ≥2; need not be a power of two.
- `aw`, default `$clog2(depth)`: address width; derived, do not override.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `we`, input, 1: write enable.
- `waddr`, input, `aw`: write address.
- `wdata`, input, `n`: write data.
- `ra0`, input, `aw`: read address for port 0.
- `ra1`, input, `aw`: read address for port 1.
- `rd0`, output, `n`: registered read data for port 0.
- `rd1`, output, `n`: registered read data for port 1.
- `clr`, input, 1: start a clear sweep (single-cycle pulse expected).
- `busy`, output, 1: clear sweep in progress.
- `werr`, output, 1: one-cycle pulse; a write was dropped.

## Operation
- Reset (`rst`=1 at an edge):
  - all words become 0; `rd0`, `rd1` = 0; `busy` = 0; `werr` = 0; FSM enters IDLE; sweep index = 0.
  - `rst` overrides every other input, including mid-sweep.
- FSM states: IDLE and CLEAR.
  - IDLE → CLEAR when `clr`=1.
  - CLEAR → IDLE after the write to index `depth-1`.
  - `clr` in CLEAR is ignored; the sweep is not restarted.
- IDLE write: if `we`=1 and `waddr` < `depth`, then `mem[waddr]` ← `wdata`.
- CLEAR write:
  - each cycle, `mem[idx]` ← 0 and `idx` increments; `idx` returns to 0 on exit.
  - any `we`=1 in CLEAR is dropped and `werr` pulses 1 on the following cycle.
- Out-of-range address (≥ `depth`): write is silently ignored (no `werr`); read returns 0.
- Read, every cycle on each port independently: `rdX` ← `mem[raX]`, with bypass in priority order:
  1. In CLEAR with `raX` == `idx`: `rdX` ← 0.
  2. Else, a write is accepted this cycle with `waddr` == `raX`: `rdX` ← `wdata`.
  3. Else: stored value.
- Both ports may read the same address; both return identical data.
- `clr` and `we` in the same IDLE cycle: the write is accepted (that edge is still IDLE). Word 0 is cleared on the next edge, so a write to address 0 is overwritten.

## Timing
- Read latency is 1 cycle: address presented before edge k, data valid after edge k.
- Write is visible to a read issued in the same cycle via bypass, and to all later reads.
- `busy` rises at the edge that samples `clr`. It stays high for exactly `depth` cycles while words 0..`depth-1` are cleared, one per cycle, then falls.
- Data writes resume on the first cycle with `busy`=0.
- `werr` is registered: high the cycle after the dropped write, low otherwise.

## Structure
- Shared package `regfile_pkg`:
  - FSM state enum (IDLE, CLEAR).
  - default `n`/`depth` constants.
- One natural sub-module, `regn_sc`: an n-bit register with load enable and synchronous clear, instantiated `depth` times.
- Address decode, bypass muxes and the FSM live in the top level.

## Test plan
All scenarios use `n`=8, `depth`=8.
- **Reset then read all:** apply `rst`, then read addresses 0..7 on both ports → every `rd0`/`rd1` = 0x00, `busy`=0.
- **Write/read and bypass:**
  - write 0xE3 to address 3, then read `ra0`=3 → `rd0`=0xE3 one cycle later.
  - same cycle write 0x5A to address 5 with `ra1`=5 → `rd1`=0x5A after that edge.
- **Clear sweep:**
  - fill words with 0x11..0x88, then pulse `clr` → `busy` high for exactly 8 cycles.
  - afterwards all words read 0x00.
  - `ra0`=2 tracked during the sweep returns 0x33 until idx passes 2, then 0x00.
- **Write during sweep:**
  - `we`=1, `waddr`=6, `wdata`=0xFF on sweep cycle 2 → `werr`=1 for one cycle; word 6 reads 0x00 after the sweep.
  - second `clr` mid-sweep → no extension; `busy` still drops after 8 cycles.
- **Reset mid-sweep:** `rst` on sweep cycle 4 → next cycle `busy`=0, all words 0x00, and a write of 0x42 to address 7 is accepted immediately.
- **Out-of-range (`depth`=6 build):** write 0x99 to address 7 → no change, `werr`=0; read address 7 → 0x00.
